pipelined_adder_n_bit: RTL and testbench

- Parametrised, pipelined add/subtract unit. Successor to the combinational ripple N-bit adder in the ALU.
- Operand width is split into CHUNK-bit slices. Each pipeline stage resolves one slice and registers the carry into the next stage, so clock frequency no longer degrades with WIDTH.
- Has a valid/ready handshake with full-pipeline back-pressure. Produces carry, signed-overflow and zero flags for the ALU result mux.

---
 rtl/pipelined_adder_n_bit.sv | 137 +++++++++++++
 tb/tb_pipelined_adder_n_bit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_n_bit.sv
// Pipelined add/subtract unit. The operand is split into CHUNK-bit slices and
// each pipeline stage resolves one slice, registering its carry into the next
// stage. Valid/ready handshake with whole-pipeline back-pressure. Carry,
// signed-overflow and zero flags are registered alongside the final result.
module pipelined_adder_n_bit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned LAST   = STAGES - 1;

  // Registered pipeline state, one entry per stage.
  // a_q/b_q carry the not-yet-added upper operand slices; s_q accumulates the
  // resolved lower result slices; c_q is the carry into the next slice.
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;

  // Values each stage will load on the next advancing edge.
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [CHUNK:0]    slice_sum [STAGES];
  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] v_d;

  logic advance;
  logic overflow_d;
  logic zero_d;
  logic cout_q;
  logic overflow_q;
  logic zero_q;

  // Whole pipeline moves together; it stalls only when the output is held.
  always_comb begin
    advance = !v_q[LAST] || out_ready;
  end

  // Stage inputs: stage 0 from the ports (subtract folded into ~B and a
  // carry-in of 1), later stages from the previous stage's registers.
  always_comb begin
    a_d[0]   = in_a;
    b_d[0]   = op_sub ? ~in_b : in_b;
    c_src[0] = op_sub ? 1'b1 : cin;
    s_src[0] = '0;
    v_d[0]   = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      c_src[k] = c_q[k-1];
      s_src[k] = s_q[k-1];
      v_d[k]   = v_q[k-1];
    end
  end

  // Per-stage slice adder: resolve slice k, pass lower result slices through.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      slice_sum[k] = {1'b0, a_d[k][k*CHUNK +: CHUNK]}
                   + {1'b0, b_d[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, c_src[k]};
      s_d[k] = s_src[k];
      s_d[k][k*CHUNK +: CHUNK] = slice_sum[k][CHUNK-1:0];
      c_d[k] = slice_sum[k][CHUNK];
    end
  end

  // Final-stage flags. Carry into the MSB is recovered as a^b^sum at that bit.
  always_comb begin
    overflow_d = a_d[LAST][WIDTH-1] ^ b_d[LAST][WIDTH-1]
               ^ s_d[LAST][WIDTH-1] ^ c_d[LAST];
    zero_d     = (s_d[LAST] == '0);
  end

  // Pipeline registers. Data only loads behind a valid token so the output
  // keeps its last result while bubbles drain through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q        <= '0;
      c_q        <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      v_q <= v_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (v_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (v_d[LAST]) begin
        cout_q     <= c_d[LAST];
        overflow_q <= overflow_d;
        zero_q     <= zero_d;
      end
    end
  end

  // Output drive.
  always_comb begin
    in_ready  = advance;
    out_valid = v_q[LAST];
    out       = s_q[LAST];
    cout      = cout_q;
    overflow  = overflow_q;
    zero      = zero_q;
  end

endmodule

// File: tb/tb_pipelined_adder_n_bit.sv
// Self-checking bench: 16-bit/4-stage and 8-bit/1-stage instances checked
// cycle by cycle against an arithmetic reference model and a result queue.
module tb_pipelined_adder_n_bit;

  localparam int S16 = 4;
  localparam int S8  = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, op_sub, out_valid, out_ready;
  logic        cout, overflow, zero;
  logic [15:0] in_a, in_b, out;
  logic        in_valid_8, in_ready_8, cin_8, op_sub_8, out_valid_8, out_ready_8;
  logic        cout_8, overflow_8, zero_8;
  logic [7:0]  in_a_8, in_b_8, out_8;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  pipelined_adder_n_bit #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .cin(cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .cout(cout), .overflow(overflow), .zero(zero)
  );

  pipelined_adder_n_bit #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .in_a(in_a_8), .in_b(in_b_8), .cin(cin_8), .op_sub(op_sub_8),
    .out_valid(out_valid_8), .out_ready(out_ready_8), .out(out_8),
    .cout(cout_8), .overflow(overflow_8), .zero(zero_8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {zero, overflow, cout, out}.
  function automatic logic [18:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] b, input logic ci,
                                        input logic sub);
    longint m, ua, ub, sa, sb, r, ts;
    logic   c;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (sub) begin
      r = ua - ub; c = (ua >= ub); ts = sa - sb;
    end else begin
      r = ua + ub + longint'(ci); c = (r >= m); ts = sa + sb + longint'(ci);
    end
    r = r & (m - 1);
    return {(r == 0), (ts >= m / 2 || ts < -(m / 2)), c, r[15:0]};
  endfunction

  typedef struct {
    logic [18:0] res;
    int unsigned issue;
    int unsigned stalls;
    logic        seen;
  } exp_t;

  exp_t        q16[$];
  exp_t        q8[$];
  exp_t        e16, e8;
  int unsigned st16 = 0;
  logic        hold16 = 1'b0;
  logic [18:0] prev16;

  // Compare process: handshake rule, stall stability, in-order results,
  // exact latency whenever no stall happened while the result was in flight.
  always @(negedge clk) begin
    if (!rst_n) begin
      q16.delete();
      q8.delete();
      hold16 = 1'b0;
      chk("rst_out_valid16", out_valid, 1'b0);
      chk("rst_out_valid8", out_valid_8, 1'b0);
    end else begin
      chk("in_ready16", in_ready, !out_valid || out_ready);
      if (hold16) chk("stall_hold16", {out_valid, zero, overflow, cout, out}, {1'b1, prev16});
      if (out_valid) begin
        if (q16.size() == 0) chk("spurious16", out_valid, 1'b0);
        else begin
          e16 = q16[0];
          chk("result16", {zero, overflow, cout, out}, e16.res);
          if (!e16.seen && e16.stalls == st16) chk("latency16", cyc - e16.issue, S16);
          e16.seen = 1'b1;
          q16[0] = e16;
          if (out_ready) void'(q16.pop_front());
        end
      end else if (q16.size() > 0 && q16[0].stalls == st16 && cyc >= q16[0].issue + S16)
        chk("late16", out_valid, 1'b1);
      hold16 = out_valid && !out_ready;
      prev16 = {zero, overflow, cout, out};
      if (hold16) st16++;
      if (in_valid && in_ready) begin
        e16.res = model(16, in_a, in_b, cin, op_sub);
        e16.issue = cyc; e16.stalls = st16; e16.seen = 1'b0;
        q16.push_back(e16);
      end

      chk("in_ready8", in_ready_8, !out_valid_8 || out_ready_8);
      if (out_valid_8) begin
        if (q8.size() == 0) chk("spurious8", out_valid_8, 1'b0);
        else begin
          e8 = q8[0];
          chk("result8", {zero_8, overflow_8, cout_8, 8'h00, out_8}, e8.res);
          chk("latency8", cyc - e8.issue, S8);
          if (out_ready_8) void'(q8.pop_front());
        end
      end else if (q8.size() > 0 && cyc >= q8[0].issue + S8)
        chk("late8", out_valid_8, 1'b1);
      if (in_valid_8 && in_ready_8) begin
        e8.res = model(8, {8'h00, in_a_8}, {8'h00, in_b_8}, cin_8, op_sub_8);
        e8.issue = cyc; e8.stalls = 0; e8.seen = 1'b0;
        q8.push_back(e8);
      end
    end
  end

  task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sub);
    in_a = a; in_b = b; cin = ci; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sub);
    in_a_8 = a; in_b_8 = b; cin_8 = ci; op_sub_8 = sub; in_valid_8 = 1'b1;
    @(posedge clk); #1;
    in_valid_8 = 1'b0;
  endtask

  // Waits (bounded) for the next result of dut d and pins it to literals.
  task automatic wait_res(input int d, input string nm, input logic [15:0] eo,
                          input logic ec, input logic ev, input logic ez);
    int n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if ((d == 0) ? out_valid : out_valid_8) break;
    end
    if (d == 0) begin
      chk({nm, "_valid"}, out_valid, 1'b1);
      chk({nm, "_cycles"}, n, S16);
      chk({nm, "_flags_out"}, {zero, overflow, cout, out}, {ez, ev, ec, eo});
    end else begin
      chk({nm, "_valid"}, out_valid_8, 1'b1);
      chk({nm, "_cycles"}, n, S8);
      chk({nm, "_flags_out"}, {zero_8, overflow_8, cout_8, out_8}, {ez, ev, ec, eo[7:0]});
    end
  endtask

  logic [15:0] ra [10];
  logic [15:0] rb [10];
  logic        rc [10];
  logic        rs [10];

  initial begin
    int idx, guard, cnt;
    logic acc;
    rst_n = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; cin = 1'b0; op_sub = 1'b0; out_ready = 1'b1;
    in_valid_8 = 1'b0; in_a_8 = '0; in_b_8 = '0; cin_8 = 1'b0; op_sub_8 = 1'b0; out_ready_8 = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state16", {out_valid, zero, overflow, cout, out}, 20'h0);
    chk("reset_state8", {out_valid_8, zero_8, overflow_8, cout_8, out_8}, 12'h0);
    rst_n = 1'b1;
    #1 chk("in_ready_after_reset", in_ready, 1'b1);

    issue16(16'h1234, 16'h0001, 1'b0, 1'b0); wait_res(0, "add",      16'h1235, 0, 0, 0);
    issue16(16'hFFFF, 16'h0000, 1'b1, 1'b0); wait_res(0, "ripple",   16'h0000, 1, 0, 1);
    issue16(16'h7FFF, 16'h0001, 1'b0, 1'b0); wait_res(0, "add_ovf",  16'h8000, 0, 1, 0);
    issue16(16'h8000, 16'h0001, 1'b0, 1'b1); wait_res(0, "sub_ovf",  16'h7FFF, 1, 1, 0);
    issue16(16'h8000, 16'h0001, 1'b1, 1'b1); wait_res(0, "sub_ovf_cin", 16'h7FFF, 1, 1, 0);
    issue16(16'h0003, 16'h0005, 1'b0, 1'b1); wait_res(0, "sub_brw",  16'hFFFE, 0, 0, 0);
    issue16(16'h0003, 16'h0005, 1'b1, 1'b1); wait_res(0, "sub_brw_cin", 16'hFFFE, 0, 0, 0);

    // Back-to-back stream under random back-pressure.
    for (int i = 0; i < 10; i++) begin
      ra[i] = 16'($urandom); rb[i] = 16'($urandom);
      rc[i] = 1'($urandom); rs[i] = 1'($urandom);
    end
    idx = 0; guard = 0;
    while ((idx < 10 || q16.size() > 0) && guard < 500) begin
      out_ready = 1'($urandom_range(0, 1));
      if (idx < 10) begin
        in_a = ra[idx]; in_b = rb[idx]; cin = rc[idx]; op_sub = rs[idx]; in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1 acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_issued", idx, 10);
    chk("stream_drained", q16.size(), 0);

    // Reset with operations in flight.
    for (int i = 0; i < 4; i++) begin
      in_a = 16'(i + 1); in_b = 16'h0100; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("pre_reset_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1 chk("async_reset_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("no_stale_results", cnt, 0);
    issue16(16'h0002, 16'h0003, 1'b0, 1'b0); wait_res(0, "post_reset", 16'h0005, 0, 0, 0);

    // Single-stage instance.
    issue8(8'hFF, 8'h01, 1'b0, 1'b0); wait_res(1, "w8_wrap", 16'h0000, 1, 0, 1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      in_a_8 = 8'(i * 37); in_b_8 = 8'(i * 91 + 5); cin_8 = i[0]; op_sub_8 = i[1];
      in_valid_8 = 1'b1;
      @(posedge clk); #1;
      if (out_valid_8) cnt++;
    end
    in_valid_8 = 1'b0;
    chk("w8_throughput", cnt, 6);
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
